// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing defaults, total derivation and delay-line bundle
// Contents: *_DEF timing constants, h_total/v_total helpers, vga_pix_t pipeline record
package vga_pkg;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    // vld marks entries that came from a real fetch, so pipeline fill slots never raise markers
    typedef struct packed {
        logic        vld;
        logic [15:0] x;
        logic [15:0] y;
        logic        en;
        logic        hs;
        logic        vs;
    } vga_pix_t;
    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction
    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register of vga_pix_t, advancing only on ce_i
// Ports: clk, rst (sync active-low), ce_i shift enable, idle_i reset value,
//        din_i stage input, dout_o last stage, nxt_o value the last stage loads on the next shift
module vga_delay_line import vga_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce_i,
    input  vga_pix_t idle_i,
    input  vga_pix_t din_i,
    output vga_pix_t dout_o,
    output vga_pix_t nxt_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, ce_i, idle_i};
            assign dout_o    = din_i;
            assign nxt_o     = din_i;
        end else begin : g_shift
            vga_pix_t stg_q [DEPTH];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) stg_q[i] <= idle_i;
                end else if (ce_i) begin
                    stg_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
                end
            end
            assign dout_o = stg_q[DEPTH-1];
            if (DEPTH == 1) begin : g_n1
                assign nxt_o = din_i;
            end else begin : g_nn
                assign nxt_o = stg_q[DEPTH-2];
            end
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with pixel clock-enable, look-ahead fetch and frame markers
// Ports: clk, rst (sync active-low), pix_ce pixel tick; fetch_x/fetch_y/fetch_en look-ahead coordinate;
//        vga_x/vga_y/video_on/hs/vs display timing; line_start/frame_start one-clk markers; frame_cnt
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int LOOKAHEAD = 2,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y,
    output logic          fetch_en,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic          video_on,
    output logic          hs,
    output logic          vs,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [XW-1:0] H_ACT_W = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_W = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST  = YW'(V_TOTAL - 1);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);
    localparam vga_pix_t IDLE = '{vld: 1'b0, x: '0, y: '0, en: 1'b0, hs: ~HS_ON, vs: ~VS_ON};

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic [15:0]   fc_q, fc_d;
    logic          h_last, v_last, ls_q, fs_q;
    vga_pix_t      f_q, f_d, disp, dl_nxt, nxt;

    always_comb begin
        h_last   = h_q == H_LAST;
        v_last   = v_q == V_LAST;
        h_d      = h_last ? '0 : h_q + 1'b1;
        v_d      = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
        fc_d     = fc_q + 16'(h_last && v_last);
        f_d      = IDLE;
        f_d.vld  = 1'b1;
        f_d.x    = 16'(h_q);
        f_d.y    = 16'(v_q);
        f_d.en   = h_q < H_ACT_W && v_q < V_ACT_W;
        f_d.hs   = (h_q >= HS_BEG && h_q < HS_END) ? HS_ON : ~HS_ON;
        f_d.vs   = (v_q >= VS_BEG && v_q < VS_END) ? VS_ON : ~VS_ON;
        // markers are registered from the value the display stage is about to load
        nxt      = (LOOKAHEAD == 0) ? f_d : dl_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q  <= '0;
            v_q  <= '0;
            fc_q <= '0;
            f_q  <= IDLE;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            if (pix_ce) begin
                h_q  <= h_d;
                v_q  <= v_d;
                fc_q <= fc_d;
                f_q  <= f_d;
            end
            ls_q <= pix_ce && nxt.vld && nxt.x == '0;
            fs_q <= pix_ce && nxt.vld && nxt.x == '0 && nxt.y == '0;
        end
    end

    vga_delay_line #(.DEPTH(LOOKAHEAD)) u_dly (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (pix_ce),
        .idle_i (IDLE),
        .din_i  (f_q),
        .dout_o (disp),
        .nxt_o  (dl_nxt)
    );

    logic unused_ok;
    assign unused_ok   = ^{disp, f_q, nxt};
    assign fetch_x     = XW'(f_q.x);
    assign fetch_y     = YW'(f_q.y);
    assign fetch_en    = f_q.en;
    assign vga_x       = XW'(disp.x);
    assign vga_y       = YW'(disp.y);
    assign video_on    = disp.en;
    assign hs          = disp.hs;
    assign vs          = disp.vs;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table-driven check of default, look-ahead, slow-ce, reset and polarity behaviour
module tb_vga_timing_gen;
    logic clk = 1'b0, rst = 1'b0, ce_a = 1'b1, ce_b = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] a_fx, a_fy, a_vx, a_vy, b_fx, b_fy, b_vx, b_vy, c_fx, c_fy, c_vx, c_vy;
    logic [9:0] s_fx, s_fy, s_vx, s_vy, p_fx, p_fy, p_vx, p_vy;
    logic a_fe, a_on, a_hs, a_vs, a_ls, a_fs, b_fe, b_on, b_hs, b_vs, b_ls, b_fs;
    logic c_fe, c_on, c_hs, c_vs, c_ls, c_fs, s_fe, s_on, s_hs, s_vs, s_ls, s_fs;
    logic p_fe, p_on, p_hs, p_vs, p_ls, p_fs;
    logic [15:0] a_fc, b_fc, c_fc, s_fc, p_fc;

    vga_timing_gen #(.LOOKAHEAD(0)) ua (.clk(clk), .rst(rst), .pix_ce(ce_a),
        .fetch_x(a_fx), .fetch_y(a_fy), .fetch_en(a_fe), .vga_x(a_vx), .vga_y(a_vy), .video_on(a_on),
        .hs(a_hs), .vs(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc));
    vga_timing_gen #(.LOOKAHEAD(2)) ub (.clk(clk), .rst(rst), .pix_ce(ce_a),
        .fetch_x(b_fx), .fetch_y(b_fy), .fetch_en(b_fe), .vga_x(b_vx), .vga_y(b_vy), .video_on(b_on),
        .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc));
    vga_timing_gen #(.LOOKAHEAD(0)) uc (.clk(clk), .rst(rst), .pix_ce(ce_b),
        .fetch_x(c_fx), .fetch_y(c_fy), .fetch_en(c_fe), .vga_x(c_vx), .vga_y(c_vy), .video_on(c_on),
        .hs(c_hs), .vs(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
        .V_BP(3), .LOOKAHEAD(0)) us (.clk(clk), .rst(rst), .pix_ce(ce_a),
        .fetch_x(s_fx), .fetch_y(s_fy), .fetch_en(s_fe), .vga_x(s_vx), .vga_y(s_vy), .video_on(s_on),
        .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc));
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
        .V_BP(3), .HS_POL(1), .VS_POL(1), .LOOKAHEAD(0)) up (.clk(clk), .rst(rst), .pix_ce(ce_a),
        .fetch_x(p_fx), .fetch_y(p_fy), .fetch_en(p_fe), .vga_x(p_vx), .vga_y(p_vy), .video_on(p_on),
        .hs(p_hs), .vs(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc));

    typedef struct {
        int k;
        int x;
        int y;
        bit on;
        bit hs;
        bit ls;
        bit fs;
    } vec_t;
    vec_t tab [11];
    int n_chk = 0, n_fail = 0, cur = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cur, act, exp);
        end
    endtask

    initial begin
        int ls_a = 0, ls_c = 0, fs_a = 0, fs_s = 0, ls_s = 0;
        int sv = 0, sh = 0, pv = 0, ph = 0, sv0 = -1, sh0 = -1, pv0 = -1, ph0 = -1;
        tab[0]  = '{0,    0,   0, 1, 1, 1, 1};
        tab[1]  = '{1,    1,   0, 1, 1, 0, 0};
        tab[2]  = '{639,  639, 0, 1, 1, 0, 0};
        tab[3]  = '{640,  640, 0, 0, 1, 0, 0};
        tab[4]  = '{655,  655, 0, 0, 1, 0, 0};
        tab[5]  = '{656,  656, 0, 0, 0, 0, 0};
        tab[6]  = '{751,  751, 0, 0, 0, 0, 0};
        tab[7]  = '{752,  752, 0, 0, 1, 0, 0};
        tab[8]  = '{799,  799, 0, 0, 1, 0, 0};
        tab[9]  = '{800,  0,   1, 1, 1, 1, 0};
        tab[10] = '{1440, 640, 1, 0, 1, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_fx", a_fx, 0);
        chk("rst_a_fe", a_fe, 0);
        chk("rst_a_on", a_on, 0);
        chk("rst_a_hs", a_hs, 1);
        chk("rst_a_vs", a_vs, 1);
        chk("rst_a_ls", a_ls, 0);
        chk("rst_a_fs", a_fs, 0);
        chk("rst_a_fc", a_fc, 0);
        chk("rst_b_hs", b_hs, 1);
        chk("rst_p_hs", p_hs, 0);
        chk("rst_p_vs", p_vs, 0);
        @(negedge clk);
        rst = 1'b1;
        ce_b = 1'b1;
        for (int cyc = 0; cyc <= 5800; cyc++) begin
            @(posedge clk);
            #1;
            cur = cyc;
            ls_a += int'(a_ls);
            ls_c += int'(c_ls);
            fs_a += int'(a_fs);
            for (int i = 0; i < 11; i++) begin
                if (cyc == tab[i].k) begin
                    chk("a_fx", a_fx, tab[i].x);
                    chk("a_fy", a_fy, tab[i].y);
                    chk("a_vx", a_vx, tab[i].x);
                    chk("a_vy", a_vy, tab[i].y);
                    chk("a_on", a_on, tab[i].on);
                    chk("a_hs", a_hs, tab[i].hs);
                    chk("a_vs", a_vs, 1);
                    chk("a_ls", a_ls, tab[i].ls);
                    chk("a_fs", a_fs, tab[i].fs);
                    chk("b_fx", b_fx, tab[i].x);
                    chk("b_fe", b_fe, tab[i].on);
                end
                if (cyc == tab[i].k + 2) begin
                    chk("b_vx", b_vx, tab[i].x);
                    chk("b_vy", b_vy, tab[i].y);
                    chk("b_on", b_on, tab[i].on);
                    chk("b_hs", b_hs, tab[i].hs);
                    chk("b_ls", b_ls, tab[i].ls);
                    chk("b_fs", b_fs, tab[i].fs);
                end
                if (cyc == 4 * tab[i].k || cyc == 4 * tab[i].k + 3) begin
                    chk("c_vx", c_vx, tab[i].x);
                    chk("c_hs", c_hs, tab[i].hs);
                    chk("c_ls", c_ls, (cyc == 4 * tab[i].k) ? tab[i].ls : 1'b0);
                    chk("c_fs", c_fs, (cyc == 4 * tab[i].k) ? tab[i].fs : 1'b0);
                end
            end
            if (cyc < 2) begin
                chk("b_fill_vx", b_vx, 0);
                chk("b_fill_on", b_on, 0);
                chk("b_fill_hs", b_hs, 1);
                chk("b_fill_fs", b_fs, 0);
            end
            ce_b = ((cyc + 1) % 4 == 0);
        end
        chk("a_ls_count", ls_a, 8);
        chk("c_ls_count", ls_c, 2);
        chk("a_fs_count", fs_a, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cur = -1;
        chk("mid_a_fx", a_fx, 0);
        chk("mid_a_fy", a_fy, 0);
        chk("mid_a_fe", a_fe, 0);
        chk("mid_a_vx", a_vx, 0);
        chk("mid_a_vy", a_vy, 0);
        chk("mid_a_on", a_on, 0);
        chk("mid_a_hs", a_hs, 1);
        chk("mid_a_vs", a_vs, 1);
        chk("mid_a_ls", a_ls, 0);
        chk("mid_a_fs", a_fs, 0);
        chk("mid_b_vx", b_vx, 0);
        chk("mid_b_hs", b_hs, 1);
        chk("mid_s_fc", s_fc, 0);
        chk("mid_p_hs", p_hs, 0);
        chk("mid_p_vs", p_vs, 0);
        rst = 1'b1;
        for (int cyc = 0; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            cur = cyc;
            if (cyc == 0) begin
                chk("rel_a_fx", a_fx, 0);
                chk("rel_a_fy", a_fy, 0);
                chk("rel_a_fs", a_fs, 1);
                chk("rel_a_fc", a_fc, 0);
            end
            if (s_fs) begin
                chk("s_fs_cyc", cyc, 195 * fs_s);
                chk("s_fc", s_fc, fs_s);
                fs_s++;
            end
            if (cyc < 195) begin
                ls_s += int'(s_ls);
                if (!s_vs) begin sv++; if (sv0 < 0) sv0 = cyc; end
                if (p_vs) begin pv++; if (pv0 < 0) pv0 = cyc; end
            end
            if (cyc < 15) begin
                if (!s_hs) begin sh++; if (sh0 < 0) sh0 = cyc; end
                if (p_hs) begin ph++; if (ph0 < 0) ph0 = cyc; end
            end
        end
        chk("s_fs_count", fs_s, 3);
        chk("s_ls_count", ls_s, 13);
        chk("s_vs_width", sv, 30);
        chk("s_vs_first", sv0, 120);
        chk("s_hs_width", sh, 3);
        chk("s_hs_first", sh0, 10);
        chk("p_vs_width", pv, 30);
        chk("p_vs_first", pv0, 120);
        chk("p_hs_width", ph, 3);
        chk("p_hs_first", ph0, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator for the debug-display path.
- Next generation of the fixed 640x480 controller: configurable timing, selectable sync polarity, and a pixel clock-enable so it runs on the 100 MHz domain.
- Provides a look-ahead fetch coordinate so the character/font buffer read latency is hidden.
- Adds frame and line markers and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hs level during sync (0 = active-low)
- VS_POL, 0, vs level during sync
- LOOKAHEAD, 2, pixel ticks by which fetch coordinates lead display outputs; legal range 0..4
- XW, 10, width of x coordinates
- YW, 10, width of y coordinates

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous reset, active-low
- pix_ce  in  1  pixel tick; timing advances only when high
- fetch_x  out  XW  column whose pixel data must be requested now
- fetch_y  out  YW  line whose pixel data must be requested now
- fetch_en  out  1  fetch coordinate lies in the active area
- vga_x  out  XW  column currently being displayed
- vga_y  out  YW  line currently being displayed
- video_on  out  1  display coordinate is in the active area
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- line_start  out  1  one-clk pulse when display x = 0
- frame_start  out  1  one-clk pulse when display (0,0) is presented
- frame_cnt  out  16  number of completed frames, wraps

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525).
- Counters: h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1.
  - Segment order is active, front porch, sync, back porch.
  - Counters change only on clk edges where pix_ce=1 and rst=1.
- Pixel tick (pix_ce=1):
  - Fetch registers load the decode of (h_cnt, v_cnt): fetch_x=h_cnt, fetch_y=v_cnt, fetch_en=(h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
  - Same tick: h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt at V_TOTAL-1 with h wrap: v_cnt wraps to 0 and frame_cnt increments, mod 2^16.
- Sync decode (computed at fetch stage):
  - hs active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Active level is HS_POL/VS_POL; inactive level is the inverse.
- Display stage: {x, y, en, hs, vs} is delayed LOOKAHEAD further pixel ticks, yielding vga_x, vga_y, video_on, hs, vs.
  - LOOKAHEAD=0: display outputs equal the fetch registers.
  - Delay stages shift only when pix_ce=1.
- pix_ce=0: all counters and registers hold.
- line_start and frame_start:
  - High for exactly one clk, on the cycle after the pix_ce tick that loads display x=0 (or display (0,0) for frame_start).
  - Low otherwise, regardless of pix_ce duty.
- Reset (rst=0, overrides pix_ce, takes effect mid-frame too):
  - h_cnt, v_cnt, frame_cnt, all coordinates = 0.
  - fetch_en, video_on, line_start, frame_start = 0.
  - hs = ~HS_POL and vs = ~VS_POL, in every delay stage.
- After reset release: the first pix_ce tick presents fetch (0,0).
  - Display reaches (0,0) LOOKAHEAD ticks later; frame_start fires then, with frame_cnt=0.
  - During this fill period display outputs keep their reset values.
- Output timing: all outputs are registered; no combinational path from pix_ce.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - a struct/bundle {x, y, en, hs, vs} for the delay line.
- One sub-module, vga_delay_line: parametrised depth (LOOKAHEAD), enable-gated shift register of that bundle, synchronous active-low reset.

Test Plan:
1. Defaults, LOOKAHEAD=0, pix_ce=1 constant after reset:
   - first tick gives fetch (0,0), video_on=1, frame_start one clk;
   - hs low for display x 656..751 (96 clk);
   - line period 800 clk.
2. Defaults, run 2 frames:
   - vs low for lines 490..491 (1600 clk);
   - frame_start period 420000 clk;
   - frame_cnt 0 -> 1 -> 2.
3. LOOKAHEAD=2:
   - vga_x/vga_y equal fetch_x/fetch_y delayed exactly 2 ticks;
   - video_on rises 2 ticks after fetch_en;
   - hs edges shift by 2.
4. pix_ce high every 4th clk:
   - outputs change only on ce cycles;
   - hs width 384 clk;
   - line_start and frame_start still one clk wide.
5. rst=0 at display (300,100) with pix_ce=1:
   - next clk all outputs at reset values, hs=vs=1;
   - after release, first tick gives fetch (0,0);
   - frame_cnt restarts at 0.
6. HS_POL=1, VS_POL=1:
   - hs/vs idle low, pulse high;
   - sync windows match scenarios 1 and 2.
